// File: rtl/cfg_reg_bank_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cfg_reg_bank_pkg                                                     |
// | Register offsets, counter width and window sizes for cfg_reg_bank.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package cfg_reg_bank_pkg;

  localparam int CNT_WIDTH      = 16;
  localparam int OFF_WIDTH      = 5;
  localparam int WIN_BYTES_BASE = 64;
  localparam int WIN_BYTES_ERR  = 128;

  // Word offsets (byte offset / 4) inside the window
  localparam logic [OFF_WIDTH-1:0] OFF_ID          = 5'd0;
  localparam logic [OFF_WIDTH-1:0] OFF_SCRATCH     = 5'd1;
  localparam logic [OFF_WIDTH-1:0] OFF_CTRL        = 5'd2;
  localparam logic [OFF_WIDTH-1:0] OFF_IRQ_STATUS  = 5'd3;
  localparam logic [OFF_WIDTH-1:0] OFF_IRQ_ENABLE  = 5'd4;
  localparam logic [OFF_WIDTH-1:0] OFF_STATUS      = 5'd5;
  localparam logic [OFF_WIDTH-1:0] OFF_PULSE       = 5'd6;
  localparam logic [OFF_WIDTH-1:0] OFF_EVENT_COUNT = 5'd7;
  localparam logic [OFF_WIDTH-1:0] OFF_ERR         = 5'd8;

  function automatic logic offset_mapped(input logic [OFF_WIDTH-1:0] off,
                                         input logic err_en);
    return (off <= OFF_EVENT_COUNT) || (err_en && (off == OFF_ERR));
  endfunction

  function automatic logic offset_read_only(input logic [OFF_WIDTH-1:0] off);
    return (off == OFF_ID) || (off == OFF_STATUS) || (off == OFF_EVENT_COUNT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cfg_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cfg_sat_counter                                                      |
// | Saturating counter adding 0/1/2 per cycle; clear+inc yields inc.     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module cfg_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH:0]   w_sum;

  assign w_base = clr ? '0 : r_count;
  assign w_sum  = {1'b0, w_base} + (WIDTH+1)'(inc);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/cfg_reg_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cfg_reg_bank                                                         |
// | Config register bank behind the bridge strobe interface.             |
// | Optional macro CFG_REG_BANK_ERR_EN adds ERR_COUNT at offset 0x20.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module cfg_reg_bank
  import cfg_reg_bank_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter logic [31:0]           ID_VALUE     = 32'hC0F1_0001,
  parameter int                    IRQ_WIDTH    = 8,
  parameter int                    STATUS_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    rd,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rvalid,
  output logic [DATA_WIDTH-1:0]   ctrl_out,
  output logic [DATA_WIDTH-1:0]   pulse_out,
  input  logic [IRQ_WIDTH-1:0]    irq_event,
  input  logic [STATUS_WIDTH-1:0] status_in,
  output logic                    irq
);

`ifdef CFG_REG_BANK_ERR_EN
  localparam int   c_win_lsb = 7;
`else
  localparam int   c_win_lsb = 6;
`endif

  logic                    w_wr_hit;
  logic                    w_rd_hit;
  logic [OFF_WIDTH-1:0]    w_woff;
  logic [OFF_WIDTH-1:0]    w_roff;
  logic                    w_we_scratch;
  logic                    w_we_ctrl;
  logic                    w_we_irq_status;
  logic                    w_we_irq_enable;
  logic                    w_we_pulse;
  logic [IRQ_WIDTH-1:0]    w_w1c_mask;
  logic [DATA_WIDTH-1:0]   w_rd_mux;
  logic [CNT_WIDTH-1:0]    w_event_count;
  logic [CNT_WIDTH-1:0]    w_err_count;
  logic                    w_event_clr;
  logic                    w_unused;

  logic [DATA_WIDTH-1:0]   r_scratch;
  logic [DATA_WIDTH-1:0]   r_ctrl;
  logic [IRQ_WIDTH-1:0]    r_irq_status;
  logic [IRQ_WIDTH-1:0]    r_irq_enable;
  logic [DATA_WIDTH-1:0]   r_pulse;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_rvalid;
  logic                    r_irq;

  assign w_wr_hit = (waddr[ADDR_WIDTH-1:c_win_lsb] == BASE_ADDR[ADDR_WIDTH-1:c_win_lsb]);
  assign w_rd_hit = (raddr[ADDR_WIDTH-1:c_win_lsb] == BASE_ADDR[ADDR_WIDTH-1:c_win_lsb]);
  assign w_woff   = OFF_WIDTH'(waddr[c_win_lsb-1:2]);
  assign w_roff   = OFF_WIDTH'(raddr[c_win_lsb-1:2]);

  assign w_we_scratch    = wr & w_wr_hit & (w_woff == OFF_SCRATCH);
  assign w_we_ctrl       = wr & w_wr_hit & (w_woff == OFF_CTRL);
  assign w_we_irq_status = wr & w_wr_hit & (w_woff == OFF_IRQ_STATUS);
  assign w_we_irq_enable = wr & w_wr_hit & (w_woff == OFF_IRQ_ENABLE);
  assign w_we_pulse      = wr & w_wr_hit & (w_woff == OFF_PULSE);

  assign w_w1c_mask  = w_we_irq_status ? wdata[IRQ_WIDTH-1:0] : '0;
  assign w_event_clr = rd & w_rd_hit & (w_roff == OFF_EVENT_COUNT);

  cfg_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_event_count (
    .clk   (clk),
    .rst   (rst),
    .inc   ({1'b0, |irq_event}),
    .clr   (w_event_clr),
    .count (w_event_count)
  );

`ifdef CFG_REG_BANK_ERR_EN
  logic       w_rd_err;
  logic       w_wr_err;
  logic       w_err_clr;
  logic [1:0] w_err_inc;

  assign w_rd_err  = rd & w_rd_hit & ~offset_mapped(w_roff, 1'b1);
  assign w_wr_err  = wr & w_wr_hit &
                     (~offset_mapped(w_woff, 1'b1) | offset_read_only(w_woff));
  assign w_err_inc = {1'b0, w_rd_err} + {1'b0, w_wr_err};
  assign w_err_clr = wr & w_wr_hit & (w_woff == OFF_ERR);

  cfg_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_err_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_err_inc),
    .clr   (w_err_clr),
    .count (w_err_count)
  );
`else
  // Without the error window, offset 0x20 decodes but has no backing register
  assign w_err_count = '0;
`endif

  always_comb begin
    w_rd_mux = '0;
    if (w_rd_hit) begin
      case (w_roff)
        OFF_ID:          w_rd_mux = DATA_WIDTH'(ID_VALUE);
        OFF_SCRATCH:     w_rd_mux = r_scratch;
        OFF_CTRL:        w_rd_mux = r_ctrl;
        OFF_IRQ_STATUS:  w_rd_mux = DATA_WIDTH'(r_irq_status);
        OFF_IRQ_ENABLE:  w_rd_mux = DATA_WIDTH'(r_irq_enable);
        OFF_STATUS:      w_rd_mux = DATA_WIDTH'(status_in);
        OFF_EVENT_COUNT: w_rd_mux = DATA_WIDTH'(w_event_count);
        OFF_ERR:         w_rd_mux = DATA_WIDTH'(w_err_count);
        default:         w_rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scratch    <= '0;
      r_ctrl       <= '0;
      r_irq_status <= '0;
      r_irq_enable <= '0;
      r_pulse      <= '0;
      r_rdata      <= '0;
      r_rvalid     <= 1'b0;
      r_irq        <= 1'b0;
    end else begin
      if (w_we_scratch)    r_scratch    <= wdata;
      if (w_we_ctrl)       r_ctrl       <= wdata;
      if (w_we_irq_enable) r_irq_enable <= wdata[IRQ_WIDTH-1:0];
      // New events are ORed after the clear so a same-cycle set survives
      r_irq_status <= (r_irq_status & ~w_w1c_mask) | irq_event;
      r_irq        <= |(r_irq_status & r_irq_enable);
      r_pulse      <= w_we_pulse ? wdata : '0;
      r_rvalid     <= rd;
      r_rdata      <= rd ? w_rd_mux : '0;
    end
  end

  assign rdata     = r_rdata;
  assign rvalid    = r_rvalid;
  assign ctrl_out  = r_ctrl;
  assign pulse_out = r_pulse;
  assign irq       = r_irq;

  assign w_unused = &{1'b0, waddr[1:0], raddr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_cfg_reg_bank.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cfg_reg_bank                                                      |
// | Self-checking bench for cfg_reg_bank (honours CFG_REG_BANK_ERR_EN).  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_cfg_reg_bank;

`ifdef CFG_REG_BANK_ERR_EN
  localparam bit ERR_EN = 1'b1;
  localparam int WIN    = 128;
`else
  localparam bit ERR_EN = 1'b0;
  localparam int WIN    = 64;
`endif

  logic        clk = 1'b0;
  logic        rst, wr, rd, rvalid, irq;
  logic [31:0] waddr, wdata, raddr, rdata, ctrl_out, pulse_out;
  logic [7:0]  irq_event;
  logic [15:0] status_in;

  always #5 clk = ~clk;

  cfg_reg_bank dut (
    .clk       (clk),
    .rst       (rst),
    .wr        (wr),
    .waddr     (waddr),
    .wdata     (wdata),
    .rd        (rd),
    .raddr     (raddr),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .ctrl_out  (ctrl_out),
    .pulse_out (pulse_out),
    .irq_event (irq_event),
    .status_in (status_in),
    .irq       (irq)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: architectural register values plus expected outputs
  logic [31:0] m_scratch, m_ctrl;
  logic [7:0]  m_st, m_en;
  int          m_evcnt, m_errcnt;
  logic        e_rvalid, e_irq;
  logic [31:0] e_rdata, e_pulse;

  typedef struct {
    logic        w;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        r;
    logic [31:0] ra;
    logic [7:0]  ev;
    logic [15:0] st;
    logic        x_rvalid;
    logic [31:0] x_rdata;
    logic [31:0] x_pulse;
    logic        x_irq;
    logic [31:0] x_ctrl;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_hit(input logic [31:0] a);
    return (a / WIN) == 0;
  endfunction

  function automatic int m_off(input logic [31:0] a);
    return int'((a % WIN) / 4);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic [15:0] st);
    if (!m_hit(a)) return 32'h0;
    case (m_off(a))
      0:       return 32'hC0F1_0001;
      1:       return m_scratch;
      2:       return m_ctrl;
      3:       return {24'h0, m_st};
      4:       return {24'h0, m_en};
      5:       return {16'h0, st};
      7:       return 32'(m_evcnt);
      8:       return ERR_EN ? 32'(m_errcnt) : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  // Drive one cycle, advance the model, optionally compare all outputs against it
  task automatic cycle(input logic rs, input logic w, input logic [31:0] wa,
                       input logic [31:0] wd, input logic r, input logic [31:0] ra,
                       input logic [7:0] ev, input logic [15:0] st, input bit chk);
    int wo, ro, nerr;
    logic [7:0] w1c;
    rst = rs; wr = w; waddr = wa; wdata = wd; rd = r; raddr = ra;
    irq_event = ev; status_in = st;
    wo = m_off(wa);
    ro = m_off(ra);
    if (rs) begin
      m_scratch = 0; m_ctrl = 0; m_st = 0; m_en = 0; m_evcnt = 0; m_errcnt = 0;
      e_rvalid = 0; e_rdata = 0; e_pulse = 0; e_irq = 0;
    end else begin
      e_rvalid = r;
      e_rdata  = r ? m_read(ra, st) : 32'h0;
      e_pulse  = (w && m_hit(wa) && wo == 6) ? wd : 32'h0;
      e_irq    = |(m_st & m_en);
      w1c      = (w && m_hit(wa) && wo == 3) ? wd[7:0] : 8'h0;
      m_st     = (m_st & ~w1c) | ev;
      if (w && m_hit(wa)) begin
        if (wo == 1) m_scratch = wd;
        if (wo == 2) m_ctrl = wd;
        if (wo == 4) m_en = wd[7:0];
      end
      if (r && m_hit(ra) && ro == 7) m_evcnt = 0;
      if (ev != 0) m_evcnt = m_evcnt + 1;
      if (m_evcnt > 65535) m_evcnt = 65535;
      if (ERR_EN) begin
        nerr = 0;
        if (r && m_hit(ra) && ro > 8) nerr++;
        if (w && m_hit(wa) && (wo > 8 || wo == 0 || wo == 5 || wo == 7)) nerr++;
        if (w && m_hit(wa) && wo == 8) m_errcnt = 0;
        m_errcnt = m_errcnt + nerr;
        if (m_errcnt > 65535) m_errcnt = 65535;
      end
    end
    @(posedge clk);
    #1;
    if (chk) begin
      check("rvalid", {31'h0, rvalid}, {31'h0, e_rvalid});
      check("rdata", rdata, e_rdata);
      check("pulse_out", pulse_out, e_pulse);
      check("irq", {31'h0, irq}, {31'h0, e_irq});
      check("ctrl_out", ctrl_out, m_ctrl);
    end
  endtask

  task automatic do_rd(input logic [31:0] a, input logic [7:0] ev);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, a, ev, 16'h0, 1'b1);
  endtask

  task automatic do_wr(input logic [31:0] a, input logic [31:0] d);
    cycle(1'b0, 1'b1, a, d, 1'b0, 32'h0, 8'h0, 16'h0, 1'b1);
  endtask

  task automatic idle(input logic [7:0] ev);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, ev, 16'h0, 1'b1);
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0:       a = 32'h0000_1000 + 32'($urandom_range(0, 255));
      1:       a = 32'h40 + 32'($urandom_range(0, 63));
      default: a = 32'($urandom_range(0, 63));
    endcase
    return a;
  endfunction

  initial begin
    logic [7:0] ev;
    // Reset state
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 8'h0, 16'h0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 8'h0, 16'h0, 1'b1);

    //           w  wa      wd            r  ra      ev     st        rv rdata                     pulse  irq ctrl
    tbl.push_back('{0, 32'h00, 32'h0,        1, 32'h00, 8'h00, 16'h0,    1, 32'hC0F1_0001,            32'h0, 0, 32'h0});
    tbl.push_back('{0, 32'h00, 32'h0,        1, 32'h08, 8'h00, 16'h0,    1, 32'h0,                    32'h0, 0, 32'h0});
    tbl.push_back('{1, 32'h04, 32'hDEADBEEF, 0, 32'h00, 8'h00, 16'h0,    0, 32'h0,                    32'h0, 0, 32'h0});
    tbl.push_back('{0, 32'h00, 32'h0,        1, 32'h04, 8'h00, 16'h0,    1, 32'hDEADBEEF,             32'h0, 0, 32'h0});
    tbl.push_back('{0, 32'h00, 32'h0,        1, 32'h08, 8'h00, 16'h0,    1, 32'h0,                    32'h0, 0, 32'h0});
    tbl.push_back('{0, 32'h00, 32'h0,        1, 32'h3C, 8'h00, 16'h0,    1, 32'h0,                    32'h0, 0, 32'h0});
    tbl.push_back('{0, 32'h00, 32'h0,        0, 32'h00, 8'h05, 16'h0,    0, 32'h0,                    32'h0, 0, 32'h0});
    tbl.push_back('{1, 32'h10, 32'h04,       0, 32'h00, 8'h00, 16'h0,    0, 32'h0,                    32'h0, 0, 32'h0});
    tbl.push_back('{0, 32'h00, 32'h0,        0, 32'h00, 8'h00, 16'h0,    0, 32'h0,                    32'h0, 1, 32'h0});
    tbl.push_back('{1, 32'h0C, 32'h04,       0, 32'h00, 8'h04, 16'h0,    0, 32'h0,                    32'h0, 1, 32'h0});
    tbl.push_back('{0, 32'h00, 32'h0,        0, 32'h00, 8'h00, 16'h0,    0, 32'h0,                    32'h0, 1, 32'h0});
    tbl.push_back('{1, 32'h0C, 32'h04,       0, 32'h00, 8'h00, 16'h0,    0, 32'h0,                    32'h0, 1, 32'h0});
    tbl.push_back('{0, 32'h00, 32'h0,        0, 32'h00, 8'h00, 16'h0,    0, 32'h0,                    32'h0, 0, 32'h0});
    tbl.push_back('{1, 32'h18, 32'h3,        0, 32'h00, 8'h00, 16'h0,    0, 32'h0,                    32'h3, 0, 32'h0});
    tbl.push_back('{0, 32'h00, 32'h0,        0, 32'h00, 8'h00, 16'h0,    0, 32'h0,                    32'h0, 0, 32'h0});
    tbl.push_back('{0, 32'h00, 32'h0,        1, 32'h18, 8'h00, 16'h0,    1, 32'h0,                    32'h0, 0, 32'h0});
    tbl.push_back('{1, 32'h08, 32'hA5,       0, 32'h00, 8'h00, 16'h0,    0, 32'h0,                    32'h0, 0, 32'hA5});
    tbl.push_back('{0, 32'h00, 32'h0,        1, 32'h0C, 8'h00, 16'h0,    1, 32'h01,                   32'h0, 0, 32'hA5});
    tbl.push_back('{0, 32'h00, 32'h0,        1, 32'h1C, 8'h00, 16'h0,    1, 32'h02,                   32'h0, 0, 32'hA5});
    tbl.push_back('{0, 32'h00, 32'h0,        1, 32'h1C, 8'h00, 16'h0,    1, 32'h0,                    32'h0, 0, 32'hA5});
    tbl.push_back('{0, 32'h00, 32'h0,        1, 32'h20, 8'h00, 16'h0,    1, ERR_EN ? 32'h1 : 32'h0,   32'h0, 0, 32'hA5});
    tbl.push_back('{0, 32'h00, 32'h0,        1, 32'h14, 8'h00, 16'hBEEF, 1, 32'h0000BEEF,             32'h0, 0, 32'hA5});
    tbl.push_back('{0, 32'h00, 32'h0,        1, 32'h0B, 8'h00, 16'h0,    1, 32'hA5,                   32'h0, 0, 32'hA5});
    tbl.push_back('{0, 32'h00, 32'h0,        1, 32'h40, 8'h00, 16'h0,    1, 32'h0,                    32'h0, 0, 32'hA5});

    foreach (tbl[i]) begin
      cycle(1'b0, tbl[i].w, tbl[i].wa, tbl[i].wd, tbl[i].r, tbl[i].ra, tbl[i].ev, tbl[i].st, 1'b0);
      check($sformatf("vec%0d.rvalid", i), {31'h0, rvalid}, {31'h0, tbl[i].x_rvalid});
      check($sformatf("vec%0d.rdata", i), rdata, tbl[i].x_rdata);
      check($sformatf("vec%0d.pulse", i), pulse_out, tbl[i].x_pulse);
      check($sformatf("vec%0d.irq", i), {31'h0, irq}, {31'h0, tbl[i].x_irq});
      check($sformatf("vec%0d.ctrl", i), ctrl_out, tbl[i].x_ctrl);
    end

    // Same-cycle read and write of SCRATCH returns the old value
    cycle(1'b0, 1'b1, 32'h04, 32'h1234_5678, 1'b1, 32'h04, 8'h0, 16'h0, 1'b1);
    check("rw_same.old", rdata, 32'hDEADBEEF);
    do_rd(32'h04, 8'h0);
    check("rw_same.new", rdata, 32'h1234_5678);

    // Reset during a read drops the response; events during reset are lost
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h00, 8'hFF, 16'h0, 1'b1);
    check("rst_mid.rvalid", {31'h0, rvalid}, 32'h0);
    do_rd(32'h0C, 8'h0);
    check("rst_mid.irq_status", rdata, 32'h0);

    // Event counter saturation and clear-on-read corner cases
    for (int i = 0; i < 70000; i++)
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 8'h01, 16'h0, 1'b0);
    do_rd(32'h1C, 8'h0);
    check("evcnt.sat", rdata, 32'h0000FFFF);
    idle(8'h10); idle(8'h20); idle(8'h40);
    do_rd(32'h1C, 8'h80);
    check("evcnt.three", rdata, 32'h3);
    do_rd(32'h1C, 8'h0);
    check("evcnt.read_and_event", rdata, 32'h1);

`ifdef CFG_REG_BANK_ERR_EN
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 8'h0, 16'h0, 1'b1);
    cycle(1'b0, 1'b1, 32'h00, 32'h55, 1'b1, 32'h24, 8'h0, 16'h0, 1'b1);
    do_rd(32'h20, 8'h0);
    check("errcnt.two", rdata, 32'h2);
    do_wr(32'h20, 32'h0);
    do_rd(32'h20, 8'h0);
    check("errcnt.clear", rdata, 32'h0);
`else
    do_rd(32'h20, 8'h0);
    check("off20.zero", rdata, 32'h0);
`endif

    // Randomised traffic against the model
    for (int i = 0; i < 4000; i++) begin
      ev = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0;
      cycle(($urandom_range(0, 199) == 0), 1'($urandom), rnd_addr(), $urandom,
            1'($urandom), rnd_addr(), ev, 16'($urandom), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
